// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// program_loader : assembles serial bytes into 32-bit words, writes them into
//                  instruction memory and holds the CPU pipeline in reset until
//                  the halt word has been stored.
// Revision 1.0 : initial release
// ============================================================================
module program_loader #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] HALT_WORD  = 32'hFFFFFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inStart,
    input  logic [7:0]            inByte,
    input  logic                  inByteValid,
    output logic                  outMemWrEn,
    output logic [ADDR_WIDTH-1:0] outMemAddr,
    output logic [31:0]           outMemData,
    output logic                  outCpuRst,
    output logic                  outDone,
    output logic                  outError,
    output logic [ADDR_WIDTH:0]   outWordCount
);

    localparam logic [ADDR_WIDTH-1:0] C_ADDR_MAX = {ADDR_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [31:0]           asm_q, asm_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
    logic [31:0]           mem_data_q, mem_data_d;
    logic                  mem_wr_en_q, mem_wr_en_d;
    logic                  cpu_rst_q, cpu_rst_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        asm_d        = asm_q;
        addr_d       = addr_q;
        word_count_d = word_count_q;
        mem_data_d   = mem_data_q;

        if (inStart) begin
            // Restart wins over any byte or pending write in the same cycle.
            state_d      = ST_LOAD;
            byte_cnt_d   = 2'd0;
            asm_d        = 32'd0;
            addr_d       = '0;
            word_count_d = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (inByteValid) begin
                        asm_d      = {asm_q[23:0], inByte};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            state_d      = ST_WRITE;
                            mem_data_d   = {asm_q[23:0], inByte};
                            word_count_d = word_count_q + 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    // Bytes arriving during the write cycle start the next word.
                    if (inByteValid) begin
                        asm_d      = {asm_q[23:0], inByte};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                    if (mem_data_q == HALT_WORD) begin
                        state_d = ST_DONE;
                    end else if (addr_q == C_ADDR_MAX) begin
                        state_d = ST_ERROR;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_LOAD;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        mem_wr_en_d = (state_d == ST_WRITE);
        done_d      = (state_d == ST_DONE);
        error_d     = (state_d == ST_ERROR);
        cpu_rst_d   = (state_d != ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            byte_cnt_q   <= 2'd0;
            asm_q        <= 32'd0;
            addr_q       <= '0;
            word_count_q <= '0;
            mem_data_q   <= 32'd0;
            mem_wr_en_q  <= 1'b0;
            cpu_rst_q    <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            asm_q        <= asm_d;
            addr_q       <= addr_d;
            word_count_q <= word_count_d;
            mem_data_q   <= mem_data_d;
            mem_wr_en_q  <= mem_wr_en_d;
            cpu_rst_q    <= cpu_rst_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign outMemWrEn   = mem_wr_en_q;
    assign outMemAddr   = addr_q;
    assign outMemData   = mem_data_q;
    assign outCpuRst    = cpu_rst_q;
    assign outDone      = done_q;
    assign outError     = error_q;
    assign outWordCount = word_count_q;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// tb_program_loader : directed and random stimulus against a transaction-level
//                     reference model, on a default and a 4-word instance.
// Revision 1.0 : initial release
// ============================================================================
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_start = 1'b0;
    logic [7:0]  in_byte = 8'd0;
    logic        in_valid = 1'b0;

    logic        wr_a, crst_a, done_a, err_a;
    logic [9:0]  addr_a;
    logic [31:0] data_a;
    logic [10:0] cnt_a;

    logic        wr_b, crst_b, done_b, err_b;
    logic [1:0]  addr_b;
    logic [31:0] data_b;
    logic [2:0]  cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    program_loader dut (
        .clk(clk), .rst(rst), .inStart(in_start), .inByte(in_byte),
        .inByteValid(in_valid), .outMemWrEn(wr_a), .outMemAddr(addr_a),
        .outMemData(data_a), .outCpuRst(crst_a), .outDone(done_a),
        .outError(err_a), .outWordCount(cnt_a)
    );

    program_loader #(.ADDR_WIDTH(2)) dut_small (
        .clk(clk), .rst(rst), .inStart(in_start), .inByte(in_byte),
        .inByteValid(in_valid), .outMemWrEn(wr_b), .outMemAddr(addr_b),
        .outMemData(data_b), .outCpuRst(crst_b), .outDone(done_b),
        .outError(err_b), .outWordCount(cnt_b)
    );

    // Reference model: phase of the load, word being collected, write events.
    localparam int P_IDLE = 0, P_LOAD = 1, P_DONE = 2, P_ERROR = 3;
    int          m_phase  [2];
    int          m_nbytes [2];
    logic [31:0] m_word   [2];
    int          m_addr   [2];
    int          m_count  [2];
    bit          m_wr     [2];
    logic [31:0] m_data   [2];
    int          m_amax   [2] = '{1023, 3};
    int          wr_seen  [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_phase[i] = P_IDLE; m_nbytes[i] = 0; m_word[i] = 0;
                m_addr[i] = 0; m_count[i] = 0; m_wr[i] = 0; m_data[i] = 0;
            end else if (in_start) begin
                m_phase[i] = P_LOAD; m_nbytes[i] = 0; m_word[i] = 0;
                m_addr[i] = 0; m_count[i] = 0; m_wr[i] = 0;
            end else begin
                bit accept;
                accept = in_valid && (m_phase[i] == P_LOAD);
                if (m_wr[i]) begin
                    m_wr[i] = 0;
                    if (m_data[i] == 32'hFFFFFFFF)    m_phase[i] = P_DONE;
                    else if (m_addr[i] == m_amax[i]) m_phase[i] = P_ERROR;
                    else                             m_addr[i]++;
                end
                if (accept) begin
                    m_word[i] = {m_word[i][23:0], in_byte};
                    m_nbytes[i]++;
                    if (m_nbytes[i] == 4) begin
                        m_nbytes[i] = 0;
                        m_wr[i]     = 1;
                        m_data[i]   = m_word[i];
                        m_count[i]++;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        check("wr_en",   {31'd0, wr_a},   {31'd0, m_wr[0]});
        check("addr",    {22'd0, addr_a}, m_addr[0]);
        check("data",    data_a,          m_data[0]);
        check("cpu_rst", {31'd0, crst_a}, {31'd0, m_phase[0] != P_DONE});
        check("done",    {31'd0, done_a}, {31'd0, m_phase[0] == P_DONE});
        check("error",   {31'd0, err_a},  {31'd0, m_phase[0] == P_ERROR});
        check("count",   {21'd0, cnt_a},  m_count[0]);
        check("s_wr_en",   {31'd0, wr_b},   {31'd0, m_wr[1]});
        check("s_addr",    {30'd0, addr_b}, m_addr[1]);
        check("s_data",    data_b,          m_data[1]);
        check("s_cpu_rst", {31'd0, crst_b}, {31'd0, m_phase[1] != P_DONE});
        check("s_done",    {31'd0, done_b}, {31'd0, m_phase[1] == P_DONE});
        check("s_error",   {31'd0, err_b},  {31'd0, m_phase[1] == P_ERROR});
        check("s_count",   {29'd0, cnt_b},  m_count[1]);
        if (wr_a) wr_seen[0]++;
        if (wr_b) wr_seen[1]++;
    endtask

    task automatic tick(input logic r, input logic st, input logic v, input logic [7:0] b);
        rst = r; in_start = st; in_valid = v; in_byte = b;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) tick(1, 0, 1, w[8*k +: 8]);
    endtask

    initial begin
        logic [31:0] words [5];
        words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};

        // Reset state
        tick(0, 0, 0, 8'h00);
        tick(0, 0, 0, 8'h00);
        check("rst_cpu_rst", {31'd0, crst_a}, 32'd1);
        check("rst_count",   {21'd0, cnt_a},  32'd0);

        // Bytes in IDLE are ignored
        tick(1, 0, 1, 8'hAB);
        tick(1, 0, 1, 8'hCD);
        tick(1, 0, 1, 8'hEF);
        tick(1, 0, 1, 8'h01);
        tick(1, 0, 0, 8'h00);
        check("idle_count", {21'd0, cnt_a}, 32'd0);

        // Basic load with halt word, back-to-back bytes
        tick(1, 1, 0, 8'h00);
        tick(1, 0, 1, 8'h20); tick(1, 0, 1, 8'h08);
        tick(1, 0, 1, 8'h00); tick(1, 0, 1, 8'h05);
        check("first_word", data_a, 32'h20080005);
        check("first_wr",   {31'd0, wr_a}, 32'd1);
        send_word(32'hFFFFFFFF);
        check("halt_addr", {22'd0, addr_a}, 32'd1);
        tick(1, 0, 0, 8'h00);
        check("done_n2", {31'd0, done_a}, 32'd1);
        check("cpurel",  {31'd0, crst_a}, 32'd0);
        check("cnt2",    {21'd0, cnt_a},  32'd2);

        // Bytes in DONE ignored, then restart from DONE with coincident byte
        send_word(32'h12345678);
        tick(1, 0, 0, 8'h00);
        check("done_cnt", {21'd0, cnt_a}, 32'd2);
        tick(1, 1, 1, 8'hAA);
        check("restart_done", {31'd0, done_a}, 32'd0);
        send_word(32'hCAFEF00D);
        check("drop_byte", data_a, 32'hCAFEF00D);

        // Overflow on the small instance
        tick(1, 1, 0, 8'h00);
        for (int i = 0; i < 5; i++) send_word(words[i]);
        tick(1, 0, 0, 8'h00);
        check("ovf_error", {31'd0, err_b},  32'd1);
        check("ovf_addr",  {30'd0, addr_b}, 32'd3);
        check("ovf_cnt",   {29'd0, cnt_b},  32'd4);

        // Reset mid-load abandons partial word
        tick(1, 1, 0, 8'h00);
        tick(1, 0, 1, 8'h99); tick(1, 0, 1, 8'h88);
        tick(0, 0, 0, 8'h00);
        tick(1, 1, 0, 8'h00);
        send_word(32'h0A0B0C0D);
        check("post_rst_word", data_a, 32'h0A0B0C0D);
        check("post_rst_addr", {22'd0, addr_a}, 32'd0);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            logic r, st, v;
            logic [7:0] b;
            r  = ($urandom_range(0, 599) != 0);
            st = ($urandom_range(0, 149) == 0);
            v  = ($urandom_range(0, 2) != 0);
            b  = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
            tick(r, st, v, b);
        end
        check("writes_seen", wr_seen[1] > 0 ? 32'd1 : 32'd0, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
